// File: rtl/mips_ctrl_if.sv
// mips_ctrl_if: bundle between the multicycle controller and the datapath.
//   master (controller): takes op/funct/zero/mem_ready, drives all control
//     strobes, datapath selects, instr_done, illegal_op and debug state.
//   slave (datapath side): the mirror image.
interface mips_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal_op, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore controller for a shared-memory, single-ALU
// MIPS datapath (R-type, lw, sw, beq, addi, j).
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mips_ctrl_if.master: op/funct/zero/mem_ready in; control strobes,
//        selects, alucontrol, instr_done, illegal_op, debug state out.
// Outputs decode from the state register only, except pcen (uses zero),
// the FETCH strobes and the MEMWR completion pulse (use mem_ready).
module mips_multicycle_ctrl (
  input logic        clk,
  input logic        rst,
  mips_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t     st, nx;
  logic       pcwrite, branch;
  logic       iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       instr_done, illegal_op;

  always_ff @(posedge clk) begin
    if (rst) st <= S_FETCH;
    else     st <= nx;
  end

  always_comb begin
    nx         = S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (st)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        // IR and PC load only on the cycle memory delivers the word, so a
        // stalled fetch never repeats a strobe.
        irwrite    = bus.mem_ready;
        pcwrite    = bus.mem_ready;
        nx         = bus.mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (bus.op)
          OP_R:         nx = S_EXECUTE;
          OP_LW, OP_SW: nx = S_MEMADR;
          OP_BEQ:       nx = S_BRANCH;
          OP_ADDI:      nx = S_ADDIEX;
          OP_J:         nx = S_JUMP;
          default: begin
            nx         = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        nx         = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        nx   = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        // memwrite is held for the whole access; it commits on mem_ready.
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = bus.mem_ready;
        nx         = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (bus.funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
        nx = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        nx         = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: nx = S_FETCH;
    endcase

    // Reset kills every strobe immediately (an in-flight writeback is
    // dropped) and parks the selects at their FETCH values.
    if (rst) begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b01;
      pcsrc      = 2'b00;
      alucontrol = ALU_ADD;
    end
  end

  assign bus.pcen       = pcwrite | (branch & bus.zero);
  assign bus.iord       = iord;
  assign bus.irwrite    = irwrite;
  assign bus.memwrite   = memwrite;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.instr_done = instr_done;
  assign bus.illegal_op = illegal_op;
  assign bus.state      = st;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control unit for the MIPS core. A Moore state machine sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps. It replaces the one-shot opcode decode with per-state control strobes and waits on a memory-ready handshake. It sits beside the datapath and takes `op`/`funct` from the instruction register and `zero` from the ALU.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  6  opcode from instruction register
- funct  in  6  function field from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pcen  out  1  PC load enable, `pcwrite | (branch & zero)`
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- irwrite  out  1  instruction register load
- memwrite  out  1  memory write request
- memtoreg  out  1  register write data select: 1 = MDR, 0 = ALUOut
- regdst  out  1  destination select: 1 = rd, 0 = rt
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2
- pcsrc  out  2  next PC select: 00 ALU result, 01 ALUOut, 10 jump target
- alucontrol  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- state  out  4  current state, for debug

## Operation
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 go to FETCH on the next edge.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Transitions:
  - FETCH→DECODE when mem_ready=1, else hold.
  - DECODE→MEMADR for lw/sw, EXECUTE for R-type, BRANCH for beq, ADDIEX for addi, JUMP for j. Any other opcode goes to FETCH and pulses illegal_op.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB when mem_ready=1, else hold.
  - MEMWR→FETCH when mem_ready=1, else hold.
  - MEMWB, ALUWB, BRANCH, ADDIWB and JUMP go to FETCH.
  - EXECUTE→ALUWB. ADDIEX→ADDIWB.
- Outputs in each state (every output not listed is 0):
  - FETCH: alusrcb=01, alucontrol=010, irwrite=mem_ready, pcwrite=mem_ready.
  - DECODE: alusrcb=11, alucontrol=010.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, alucontrol=010.
  - MEMRD: iord=1.
  - MEMWR: iord=1, memwrite=1 for the whole state. The write commits on the mem_ready cycle.
  - MEMWB: memtoreg=1, regwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct.
  - ALUWB: regdst=1, regwrite=1.
  - ADDIWB: regwrite=1.
  - BRANCH: alusrca=1, alucontrol=110, branch=1, pcsrc=01.
  - JUMP: pcsrc=10, pcwrite=1.
- funct decode: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct→010, with no flag.
- instr_done is 1 in:
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP;
  - MEMWR when mem_ready=1;
  - DECODE on an illegal opcode.
- op and funct are used only in DECODE and EXECUTE. The datapath holds them stable in the instruction register.

## Timing
- Reset: state is FETCH on the first edge with rst=1. While rst=1, pcen, pcwrite, irwrite, regwrite, memwrite, branch, instr_done and illegal_op are forced to 0. Every other output takes its FETCH value.
- Reset mid-instruction aborts it. No partial writeback happens after rst is sampled high.
- All outputs are combinational from state, with these exceptions: pcen also depends on zero; FETCH strobes and instr_done in MEMWR also depend on mem_ready.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each low cycle of mem_ready in FETCH, MEMRD or MEMWR adds exactly one cycle. No strobe repeats while the state holds.

## Test plan
- Reset with rst=1 for 2 cycles, with mem_ready=1 → state=0, pcen=irwrite=regwrite=memwrite=0. First FETCH strobes appear on the cycle after rst falls.
- lw (op=100011) with mem_ready=1 → states 0,1,2,3,4. regwrite=1 and memtoreg=1 only in cycle 5. instr_done pulses once.
- sw with mem_ready low for 3 cycles in MEMWR → memwrite=1 for 4 cycles. instr_done only on the mem_ready cycle. Then returns to FETCH.
- R-type with funct=101010 → alucontrol=111 in EXECUTE. Then ALUWB with regdst=1, regwrite=1. Total 4 cycles.
- beq with zero=1, then a second beq with zero=0 → pcen=1 in BRANCH for the first only, with pcsrc=01 and alucontrol=110.
- op=111111 → illegal_op and instr_done pulse in DECODE, back to FETCH. Then apply rst during MEMWB of a lw → regwrite=0 and state=0 next cycle.
